// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_JUMP      = 4'd11,
        ST_HALT      = 4'd12
    } state_t;

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - R-type funct field to ALU operation with a valid flag
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_valid
);

    always_comb begin
        o_alu_op = ALU_AND;
        o_valid  = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_op = ALU_ADD;
            FN_SUB:  o_alu_op = ALU_SUB;
            FN_AND:  o_alu_op = ALU_AND;
            FN_OR:   o_alu_op = ALU_OR;
            FN_SLT:  o_alu_op = ALU_SLT;
            default: o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory wait states,
// illegal-instruction halt and a retired-instruction counter
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int EN_ADDI = 1,
    parameter int EN_BNE  = 1,
    parameter int EN_J    = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic [2:0] w_fn_op;
    logic       w_fn_valid;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_en;
    logic       w_reg_write;
    logic       w_is_bne;

    mips_alu_decode u_alu_decode (
        .i_funct  (funct),
        .o_alu_op (w_fn_op),
        .o_valid  (w_fn_valid)
    );

    // The IR still holds the instruction in BRANCH, so the opcode picks BEQ vs BNE.
    assign w_is_bne = (EN_BNE != 0) && (opcode == OP_BNE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_HALT) begin
                r_illegal <= 1'b1;
            end
            if ((w_next == ST_FETCH) && (r_state != ST_FETCH)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_en     = 1'b0;
        w_reg_write = 1'b0;
        i_or_d      = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        alu_op      = ALU_AND;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_en    = 1'b1;
                    w_next     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     w_next = ST_R_EXEC;
                    OP_LW, OP_SW: w_next = ST_MEM_ADDR;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_BNE:       w_next = (EN_BNE != 0) ? ST_BRANCH : ST_HALT;
                    OP_ADDI:      w_next = (EN_ADDI != 0) ? ST_ADDI_EXEC : ST_HALT;
                    OP_J:         w_next = (EN_J != 0) ? ST_JUMP : ST_HALT;
                    default:      w_next = ST_HALT;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                w_next    = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                w_mem_req = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_next = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready) begin
                    w_next = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = w_fn_op;
                w_next    = w_fn_valid ? ST_R_WB : ST_HALT;
            end
            ST_R_WB: begin
                alu_op      = w_fn_op;
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                w_pc_en   = w_is_bne ? ~zero : zero;
                w_next    = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                w_next    = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                w_reg_write = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src  = PC_SRC_JUMP;
                w_pc_en = 1'b1;
                w_next  = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced low for the whole reset pulse, not just from the next edge.
    assign mem_req     = w_mem_req   & reset_n;
    assign mem_write   = w_mem_write & reset_n;
    assign ir_write    = w_ir_write  & reset_n;
    assign pc_en       = w_pc_en     & reset_n;
    assign reg_write   = w_reg_write & reset_n;
    assign illegal     = r_illegal;
    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4;
    localparam logic [3:0] S_MW = 4'd5, S_RE = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_AE = 4'd9;
    localparam logic [3:0] S_AWB = 4'd10, S_J = 4'd11, S_H = 4'd12;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, i_or_d, ir_write, pc_en, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [3:0] instr_count;

    logic       b_mem_req, b_mem_write, b_i_or_d, b_ir_write, b_pc_en, b_alu_src_a;
    logic       b_reg_dst, b_mem_to_reg, b_reg_write, b_illegal;
    logic [1:0] b_pc_src, b_alu_src_b;
    logic [2:0] b_alu_op;
    logic [3:0] b_state;
    logic [7:0] b_instr_count;

    always #5 clock = ~clock;

    mips_multicycle_ctrl #(.CNT_W(4), .EN_ADDI(1), .EN_BNE(1), .EN_J(1)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    mips_multicycle_ctrl #(.CNT_W(8), .EN_ADDI(0), .EN_BNE(0), .EN_J(0)) dut_min (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_write(b_mem_write), .i_or_d(b_i_or_d),
        .ir_write(b_ir_write), .pc_en(b_pc_en), .pc_src(b_pc_src), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .illegal(b_illegal),
        .state(b_state), .instr_count(b_instr_count)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          n;
        logic [27:0] sts;
        int          fwait;
        int          mwait;
        logic [2:0]  aop;
        logic        pce;
        logic        aop_dc;
        logic        retire;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic        ill;
        logic [15:0] outs;
        logic [15:0] mask;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[15];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_cnt = 4'd0;

    function automatic vec_t mkv(logic [5:0] op, logic [5:0] fn, logic z, int n, logic [27:0] sts,
                                 int fw, int mw, logic [2:0] aop, logic pce, logic dc, logic ret);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.n = n; v.sts = sts; v.fwait = fw; v.mwait = mw;
        v.aop = aop; v.pce = pce; v.aop_dc = dc; v.retire = ret;
        return v;
    endfunction

    // {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write}
    function automatic logic [15:0] pk(logic mr, logic mw, logic iod, logic irw, logic pce,
                                       logic [1:0] ps, logic sa, logic [1:0] sbb, logic [2:0] aop,
                                       logic rd, logic m2r, logic rw);
        return {mr, mw, iod, irw, pce, ps, sa, sbb, aop, rd, m2r, rw};
    endfunction

    function automatic logic [15:0] base_outs(logic [3:0] s);
        case (s)
            S_F:     return pk(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0);
            S_D:     return pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0);
            S_MA:    return pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0);
            S_MR:    return pk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
            S_MWB:   return pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1);
            S_MW:    return pk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
            S_RE:    return pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b000, 0, 0, 0);
            S_RWB:   return pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1);
            S_BR:    return pk(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0);
            S_AE:    return pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0);
            S_AWB:   return pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1);
            S_J:     return pk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] act_outs();
        return {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_dst, mem_to_reg, reg_write};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_sb();
        exp_t e;
        logic [15:0] a;
        if (sb.size() == 0) begin
            cmp("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        a = act_outs();
        cmp("cycle", {11'd0, state, illegal, a & e.mask}, {11'd0, e.st, e.ill, e.outs & e.mask});
    endtask

    task automatic run_entry(input vec_t v);
        logic [3:0] s;
        int         reps;
        exp_t       e;
        for (int i = 0; i < v.n; i++) begin
            s = v.sts[4*i +: 4];
            reps = 1 + ((s == S_F) ? v.fwait : ((s == S_MR || s == S_MW) ? v.mwait : 0));
            for (int r = 0; r < reps; r++) begin
                @(negedge clock);
                opcode = v.op; funct = v.fn; zero = v.z;
                if (s == S_F || s == S_MR || s == S_MW) mem_ready = (r == reps - 1);
                else mem_ready = 1'($urandom_range(0, 1));
                e.st = s; e.ill = (s == S_H); e.outs = base_outs(s); e.mask = 16'hFFFF;
                if (s == S_F && mem_ready) e.outs[12:11] = 2'b11;
                if (s == S_RE || s == S_RWB) e.outs[5:3] = v.aop;
                if (s == S_RE && v.aop_dc) e.mask[5:3] = 3'b000;
                if (s == S_BR) e.outs[11] = v.pce;
                sb.push_back(e);
                #1;
                check_sb();
            end
        end
        if (v.retire) begin
            exp_cnt = exp_cnt + 4'd1;
            @(posedge clock);
            #1;
            cmp("retire_cnt", {28'd0, instr_count}, {28'd0, exp_cnt});
            cmp("back_to_fetch", {28'd0, state}, {28'd0, S_F});
        end
    endtask

    task automatic hold_halt(input int cycles);
        exp_t e;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            mem_ready = 1'($urandom_range(0, 1));
            opcode = 6'($urandom_range(0, 63));
            e.st = S_H; e.ill = 1'b1; e.outs = 16'h0000; e.mask = 16'hFFFF;
            sb.push_back(e);
            #1;
            check_sb();
        end
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        cmp("rst_state", {28'd0, state}, {28'd0, S_F});
        cmp("rst_illegal", {31'd0, illegal}, 32'd0);
        cmp("rst_strobes", {27'd0, mem_req, mem_write, ir_write, pc_en, reg_write}, 32'd0);
        @(negedge clock);
        mem_ready = 1'b0;
        reset_n = 1'b1;
        exp_cnt = 4'd0;
        #1;
        cmp("rst_cnt", {28'd0, instr_count}, 32'd0);
    endtask

    initial begin
        logic [5:0] dis_ops[3];
        logic [3:0] dis_st[3];

        tbl[0]  = mkv(6'b000000, 6'b100000, 0, 4, 28'h0007610, 0, 0, 3'b010, 0, 0, 1);
        tbl[1]  = mkv(6'b000000, 6'b100010, 0, 4, 28'h0007610, 2, 0, 3'b110, 0, 0, 1);
        tbl[2]  = mkv(6'b000000, 6'b100100, 1, 4, 28'h0007610, 0, 0, 3'b000, 0, 0, 1);
        tbl[3]  = mkv(6'b000000, 6'b100101, 0, 4, 28'h0007610, 1, 0, 3'b001, 0, 0, 1);
        tbl[4]  = mkv(6'b000000, 6'b101010, 0, 4, 28'h0007610, 0, 0, 3'b111, 0, 0, 1);
        tbl[5]  = mkv(6'b100011, 6'b000000, 0, 5, 28'h0043210, 0, 2, 3'b000, 0, 0, 1);
        tbl[6]  = mkv(6'b101011, 6'b000000, 0, 4, 28'h0005210, 1, 1, 3'b000, 0, 0, 1);
        tbl[7]  = mkv(6'b000100, 6'b000000, 1, 3, 28'h0000810, 0, 0, 3'b000, 1, 0, 1);
        tbl[8]  = mkv(6'b000100, 6'b000000, 0, 3, 28'h0000810, 0, 0, 3'b000, 0, 0, 1);
        tbl[9]  = mkv(6'b000101, 6'b000000, 1, 3, 28'h0000810, 0, 0, 3'b000, 0, 0, 1);
        tbl[10] = mkv(6'b000101, 6'b000000, 0, 3, 28'h0000810, 0, 0, 3'b000, 1, 0, 1);
        tbl[11] = mkv(6'b001000, 6'b000000, 0, 4, 28'h000A910, 0, 0, 3'b000, 0, 0, 1);
        tbl[12] = mkv(6'b000010, 6'b000000, 0, 3, 28'h0000B10, 0, 0, 3'b000, 0, 0, 1);
        tbl[13] = mkv(6'b000000, 6'b111111, 0, 4, 28'h000C610, 0, 0, 3'b000, 0, 1, 0);
        tbl[14] = mkv(6'b111111, 6'b000000, 0, 3, 28'h0000C10, 0, 0, 3'b000, 0, 0, 0);

        reset_pulse();
        for (int i = 0; i < 15; i++) begin
            run_entry(tbl[i]);
            if (!tbl[i].retire) begin
                hold_halt(10);
                reset_pulse();
            end
        end

        dis_ops[0] = 6'b000010; dis_st[0] = S_J;
        dis_ops[1] = 6'b000101; dis_st[1] = S_BR;
        dis_ops[2] = 6'b001000; dis_st[2] = S_AE;
        for (int i = 0; i < 3; i++) begin
            reset_pulse();
            @(negedge clock); opcode = dis_ops[i]; mem_ready = 1'b1;
            @(negedge clock); mem_ready = 1'b0;
            @(negedge clock); #1;
            cmp("disabled_halt", {28'd0, b_state}, {28'd0, S_H});
            cmp("disabled_illegal", {31'd0, b_illegal}, 32'd1);
            cmp("disabled_nostrobe", {31'd0, b_mem_req | b_pc_en | b_reg_write}, 32'd0);
            cmp("enabled_path", {28'd0, state}, {28'd0, dis_st[i]});
        end

        reset_pulse();
        for (int j = 0; j < 16; j++) run_entry(tbl[12]);
        cmp("cnt_wrap", {28'd0, instr_count}, 32'd0);

        reset_pulse();
        @(negedge clock); opcode = 6'b101011; mem_ready = 1'b1;
        @(negedge clock); mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock); #1;
        cmp("sw_in_write", {29'd0, state[2:0] == 3'd5, mem_req, mem_write}, 32'd7);
        #1 reset_n = 1'b0;
        #1;
        cmp("sw_rst_state", {28'd0, state}, {28'd0, S_F});
        cmp("sw_rst_req", {30'd0, mem_req, mem_write}, 32'd0);
        @(posedge clock); #1;
        cmp("sw_rst_next", {27'd0, state, mem_req}, 32'd0);
        @(negedge clock); reset_n = 1'b1; #1;
        cmp("sw_after_rst", {27'd0, instr_count, mem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
